mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data.
// Data has priority; a starve counter guarantees fetch progress.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        freeze
);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, DONE} state_t;

    localparam int SW = 4;
    localparam int TW = 8;

    state_t          state;
    state_t          state_nx;
    logic [SW-1:0]   starve;
    logic [TW-1:0]   tcnt;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            we_q;
    logic            grant_if;
    logic            grant_dm;
    logic            in_acc;
    logic            starve_full;
    logic            timeout;

    assign in_acc      = (state == IF_ACC) || (state == DM_ACC);
    assign starve_full = (starve == SW'(STARVE_LIMIT));
    assign timeout     = (tcnt == TW'(TIMEOUT - 1));
    assign freeze      = if_req && !if_ready;

    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE) begin
            unique case (1'b1)
                if_req && dm_req: begin
                    grant_if = starve_full;
                    grant_dm = !starve_full;
                end
                if_req && !dm_req: grant_if = 1'b1;
                dm_req && !if_req: grant_dm = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_if) begin
                    state_nx = IF_ACC;
                end else if (grant_dm) begin
                    state_nx = DM_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (mem_ack || timeout) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (in_acc) begin
            mem_req   = 1'b1;
            mem_we    = we_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            starve   <= '0;
            tcnt     <= '0;
            if_rdata <= '0;
            dm_rdata <= '0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (grant_if) begin
                addr_q  <= if_addr;
                wdata_q <= '0;
                we_q    <= 1'b0;
                starve  <= '0;
            end else if (grant_dm) begin
                addr_q  <= dm_addr;
                wdata_q <= dm_wdata;
                we_q    <= dm_we;
                if (if_req && !starve_full) begin
                    starve <= starve + 1'b1;
                end
            end

            if (grant_if || grant_dm) begin
                tcnt <= '0;
            end else if (in_acc && !mem_ack) begin
                tcnt <= tcnt + 1'b1;
            end

            if (state == IF_ACC && mem_ack) begin
                if_rdata <= mem_rdata;
            end
            if (state == DM_ACC && mem_ack && !we_q) begin
                dm_rdata <= mem_rdata;
            end

            // Ready/err are high exactly for the DONE cycle.
            if_ready <= (state == IF_ACC) && (state_nx == DONE);
            dm_ready <= (state == DM_ACC) && (state_nx == DONE);
            err      <= in_acc && !mem_ack && timeout;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_mem_arbiter;

    localparam int SL = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        freeze;

    int vecs = 0;
    int errs = 0;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .freeze(freeze)
    );

    always #5 clk = ~clk;

    // Model: one outstanding transaction, a "finished" flag for the
    // completion cycle, and the last words delivered to each requester.
    bit          m_busy;
    bit          m_fin;
    bit          m_dm;
    bit          m_we;
    bit          m_err;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_ifr;
    logic [31:0] m_dmr;
    int          m_age;
    int          m_starve;

    task automatic model_reset();
        m_busy = 0; m_fin = 0; m_dm = 0; m_we = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_ifr = '0; m_dmr = '0;
        m_age = 0; m_starve = 0;
    endtask

    task automatic step();
        bit take_if;
        if (!rst) begin
            model_reset();
        end else if (m_fin) begin
            m_fin = 0;
            m_err = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                if (!m_dm) m_ifr = mem_rdata;
                else if (!m_we) m_dmr = mem_rdata;
                m_busy = 0; m_fin = 1; m_err = 0;
            end else if (m_age == TO - 1) begin
                m_busy = 0; m_fin = 1; m_err = 1;
            end else begin
                m_age++;
            end
        end else if (if_req || dm_req) begin
            take_if = if_req && (!dm_req || m_starve == SL);
            m_busy = 1; m_age = 0; m_dm = !take_if;
            m_addr  = take_if ? if_addr : dm_addr;
            m_we    = take_if ? 1'b0 : dm_we;
            m_wdata = take_if ? 32'h0 : dm_wdata;
            if (take_if) m_starve = 0;
            else if (if_req && m_starve < SL) m_starve++;
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic exr;
        logic edr;
        exr = m_fin && !m_dm;
        edr = m_fin && m_dm;
        chk("mem_req", mem_req, m_busy);
        chk("mem_addr", mem_addr, m_busy ? m_addr : 32'h0);
        chk("mem_we", mem_we, m_busy && m_we);
        if (!m_busy || m_we) chk("mem_wdata", mem_wdata, m_busy ? m_wdata : 32'h0);
        chk("if_ready", if_ready, exr);
        chk("dm_ready", dm_ready, edr);
        chk("err", err, m_fin && m_err);
        chk("if_rdata", if_rdata, m_ifr);
        chk("dm_rdata", dm_rdata, m_dmr);
        chk("freeze", freeze, if_req && !exr);
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        @(negedge clk);
        check_all();
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        if_req = 1; if_addr = a; mem_ack = 0;
        tick();
        mem_ack = 1; mem_rdata = d;
        tick();
        chk("fetch_ready", if_ready, 1);
        chk("fetch_rdata", if_rdata, d);
        chk("fetch_err", err, 0);
        if_req = 0; mem_ack = 0;
        tick();
    endtask

    task automatic rand_drive(input int ack_pct);
        bit exr;
        bit edr;
        exr = m_fin && !m_dm;
        edr = m_fin && m_dm;
        if (!if_req) begin
            if ($urandom_range(9) < 3) begin
                if_req = 1; if_addr = $urandom() & 32'hFFFF_FFFC;
            end
        end else if (exr) begin
            if ($urandom_range(1) == 1) if_req = 0;
            else if_addr = $urandom() & 32'hFFFF_FFFC;
        end else if ($urandom_range(99) < 2) begin
            if_req = 0;
        end
        if (!dm_req || edr || $urandom_range(99) < 2) begin
            dm_req = (!dm_req) ? ($urandom_range(9) < 4) : ($urandom_range(1) == 1);
            dm_we = $urandom_range(1);
            dm_addr = $urandom();
            dm_wdata = $urandom();
        end
        mem_ack = ($urandom_range(99) < ack_pct);
        mem_rdata = $urandom();
    endtask

    initial begin
        bit got[10];
        bit pat[10];
        int n;
        bit prev;

        model_reset();
        pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        @(negedge clk);
        check_all();
        tick();
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        rst = 1;
        tick();

        // Fetch-only
        if_req = 1; if_addr = 32'h10; mem_rdata = 32'hE3A01005;
        tick();
        chk("f_addr", mem_addr, 32'h10);
        chk("f_we", mem_we, 0);
        chk("f_freeze", freeze, 1);
        mem_ack = 1;
        tick();
        chk("f_ready", if_ready, 1);
        chk("f_rdata", if_rdata, 32'hE3A01005);
        chk("f_err", err, 0);
        chk("f_freeze_done", freeze, 0);
        if_req = 0; mem_ack = 0;
        tick();

        // Simultaneous: write first, then fetch
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 1; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF;
        tick();
        chk("s_we", mem_we, 1);
        chk("s_addr", mem_addr, 32'h200);
        chk("s_wdata", mem_wdata, 32'hDEADBEEF);
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        chk("s_dm_ready", dm_ready, 1);
        chk("s_dm_rdata", dm_rdata, 0);
        dm_req = 0; dm_we = 0; mem_ack = 0;
        tick();
        chk("s_gap", mem_req, 0);
        tick();
        chk("s_if_addr", mem_addr, 32'h40);
        chk("s_if_we", mem_we, 0);
        mem_ack = 1;
        tick();
        chk("s_if_ready", if_ready, 1);
        if_req = 0; mem_ack = 0;
        tick();

        // Starvation
        if_req = 1; if_addr = 32'h1000;
        dm_req = 1; dm_we = 0; dm_addr = 32'h2000;
        mem_ack = 1;
        n = 0; prev = 0;
        for (int i = 0; i < 33; i++) begin
            mem_rdata = $urandom();
            tick();
            if (mem_req && !prev && n < 10) begin
                got[n] = (mem_addr == 32'h2000);
                n++;
            end
            prev = mem_req;
        end
        chk("st_count", n, 10);
        for (int i = 0; i < 10; i++) chk("st_grant", got[i], pat[i]);
        if_req = 0; dm_req = 0;
        repeat (3) tick();
        mem_ack = 0;
        tick();

        // Timeout
        dm_req = 1; dm_we = 0; dm_addr = 32'h300;
        tick();
        mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        tick();
        chk("t_pre_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0; mem_ack = 0;
        tick();
        dm_req = 1; dm_addr = 32'h304; mem_rdata = 32'hBAD0BAD0;
        tick();
        n = mem_req ? 1 : 0;
        while (mem_req && n < 40) begin
            tick();
            if (mem_req) n++;
        end
        chk("t_cycles", n, TO);
        chk("t_ready", dm_ready, 1);
        chk("t_err", err, 1);
        chk("t_rdata", dm_rdata, 32'hCAFEF00D);
        dm_req = 0;
        tick();
        fetch(32'h44, 32'h0BADCAFE);

        // Reset in the third access cycle
        if_req = 1; if_addr = 32'h80; mem_ack = 0;
        repeat (3) tick();
        chk("r_pre", mem_req, 1);
        #1 rst = 0;
        #1 chk("r_async", mem_req, 0);
        model_reset();
        chk("r_ready", if_ready, 0);
        tick();
        tick();
        rst = 1;
        tick();
        chk("r_regrant", mem_req, 1);
        chk("r_addr", mem_addr, 32'h80);
        mem_ack = 1; mem_rdata = 32'h55AA55AA;
        tick();
        chk("r_ready2", if_ready, 1);
        if_req = 0; mem_ack = 0;
        tick();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            rand_drive(((i / 250) % 2 == 0) ? 40 : 3);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
